param_fifo: RTL and testbench

Parametrised successor to the terminal's 16-entry pulse FIFO. It buffers `DATA_WIDTH`-bit words between a producer strobing `in_data_available` and a consumer gating delivery with `receiver_ready`. Depth, almost-full threshold and output mode (one word per two cycles, or back-to-back) are configurable. It adds full/empty/level status, a sticky overflow flag with explicit drop policy, and a synchronous flush. It sits between the serial/decoder stages and the character-generation pipeline wherever a deeper or faster queue is needed.

---
 rtl/param_fifo_if.sv | 33 +++
 rtl/param_fifo.sv | 73 +++++++
 tb/tb_param_fifo.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_fifo_if.sv
// param_fifo_if: producer/consumer bundle around param_fifo.
// master drives the strobes, slave is the FIFO side.
interface param_fifo_if #(
  parameter int DATA_WIDTH = 21,
  parameter int DEPTH_LOG2 = 4
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_data_available;
  logic                  flush;
  logic                  clear_overflow;
  logic                  receiver_ready;
  logic                  out_data_available;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DEPTH_LOG2:0]   level;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;

  modport master (
    output in_data, in_data_available, flush,
    output clear_overflow, receiver_ready,
    input  out_data_available, out_data, level,
    input  empty, full, almost_full, overflow
  );

  modport slave (
    input  in_data, in_data_available, flush,
    input  clear_overflow, receiver_ready,
    output out_data_available, out_data, level,
    output empty, full, almost_full, overflow
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: parametrised word FIFO with status, sticky
// overflow, synchronous flush and paced/streaming output.
module param_fifo #(
  parameter int DATA_WIDTH  = 21,
  parameter int DEPTH_LOG2  = 4,
  parameter int ALMOST_FULL = 12,
  parameter int STREAMING   = 0
) (
  input logic         clk,
  input logic         reset,
  param_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         lvl;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  oda;
  logic                  ovf;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drop;

  // Extra pointer bit distinguishes full from empty.
  assign lvl             = wr_ptr - rd_ptr;
  assign bus.level       = lvl;
  assign bus.empty       = (lvl == '0);
  assign bus.full        = (lvl == PW'(DEPTH));
  assign bus.almost_full = (lvl >= PW'(ALMOST_FULL));

  assign bus.out_data_available = oda;
  assign bus.out_data           = out_q;
  assign bus.overflow           = ovf;

  assign wr_en = bus.in_data_available && !bus.full
               && !bus.flush;
  assign drop  = bus.in_data_available && bus.full
               && !bus.flush;
  assign rd_en = bus.receiver_ready && !bus.empty
               && ((STREAMING != 0) || !oda)
               && !bus.flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      oda    <= 1'b0;
      out_q  <= '0;
      ovf    <= 1'b0;
    end else begin
      oda <= 1'b0;
      if (bus.flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) begin
          rd_ptr <= rd_ptr + 1'b1;
          out_q  <= mem[rd_ptr[DEPTH_LOG2-1:0]];
          oda    <= 1'b1;
        end
      end
      if (drop)                    ovf <= 1'b1;
      else if (bus.clear_overflow) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_data;
  end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed checks of paced (u0) and
// streaming (u1) instances sharing one stimulus stream.
module tb_param_fifo;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  param_fifo_if #(.DATA_WIDTH(21), .DEPTH_LOG2(4)) b0 ();
  param_fifo_if #(.DATA_WIDTH(21), .DEPTH_LOG2(4)) b1 ();

  assign b1.in_data           = b0.in_data;
  assign b1.in_data_available = b0.in_data_available;
  assign b1.flush             = b0.flush;
  assign b1.clear_overflow    = b0.clear_overflow;
  assign b1.receiver_ready    = b0.receiver_ready;

  param_fifo #(.DATA_WIDTH(21), .DEPTH_LOG2(4),
               .ALMOST_FULL(12), .STREAMING(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  param_fifo #(.DATA_WIDTH(21), .DEPTH_LOG2(4),
               .ALMOST_FULL(12), .STREAMING(1)) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [20:0] d);
    b0.in_data = d;
    b0.in_data_available = 1'b1;
    cyc();
    b0.in_data_available = 1'b0;
  endtask

  logic [20:0] g0[$];
  logic [20:0] g1[$];
  logic [20:0] q0[$];
  logic [20:0] q1[$];
  logic [20:0] ev;
  logic [15:0] p0, p1;
  int cnt[2];
  bit om[2];
  bit wrm[2];
  bit popm[2];
  int n;

  task automatic collect(int cycles);
    g0.delete();
    g1.delete();
    for (int k = 0; k < cycles; k++) begin
      cyc();
      if (b0.out_data_available) g0.push_back(b0.out_data);
      if (b1.out_data_available) g1.push_back(b1.out_data);
    end
  endtask

  task automatic soak_step();
    for (int d = 0; d < 2; d++) begin
      wrm[d]  = b0.in_data_available && cnt[d] < 16;
      popm[d] = b0.receiver_ready && cnt[d] > 0
                && (d == 1 || !om[d]);
    end
    if (wrm[0]) q0.push_back(b0.in_data);
    if (wrm[1]) q1.push_back(b0.in_data);
    cyc();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = cnt[d] + int'(wrm[d]) - int'(popm[d]);
      om[d]  = popm[d];
    end
    chk("soak_lvl0", b0.level, cnt[0]);
    chk("soak_lvl1", b1.level, cnt[1]);
    chk("soak_af0", b0.almost_full, cnt[0] >= 12);
    chk("soak_af1", b1.almost_full, cnt[1] >= 12);
    chk("soak_oda0", b0.out_data_available, popm[0]);
    chk("soak_oda1", b1.out_data_available, popm[1]);
    if (popm[0] && q0.size() > 0) begin
      ev = q0.pop_front();
      chk("soak_dat0", b0.out_data, ev);
    end
    if (popm[1] && q1.size() > 0) begin
      ev = q1.pop_front();
      chk("soak_dat1", b1.out_data, ev);
    end
  endtask

  initial begin
    b0.in_data = '0;
    b0.in_data_available = 1'b0;
    b0.flush = 1'b0;
    b0.clear_overflow = 1'b0;
    b0.receiver_ready = 1'b0;

    // reset and idle
    repeat (3) cyc();
    reset = 1'b1;
    chk("rst_empty", b0.empty, 1);
    chk("rst_level", b0.level, 0);
    chk("rst_out", b0.out_data, 0);
    chk("rst_oda", b0.out_data_available, 0);
    chk("rst_ovf", b0.overflow, 0);
    chk("rst_full", b0.full, 0);
    chk("rst_af", b0.almost_full, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (b0.out_data_available || b1.out_data_available) n++;
    end
    chk("idle_pulses", n, 0);

    // fill past full with consumer stalled
    for (int i = 1; i <= 18; i++) begin
      wr(21'(i));
      if (i == 16) chk("ovf_at16", b0.overflow, 0);
      if (i == 17) chk("ovf_at17", b0.overflow, 1);
    end
    chk("fill_full", b0.full, 1);
    chk("fill_level", b0.level, 16);
    chk("fill_af", b0.almost_full, 1);
    chk("fill_level1", b1.level, 16);
    b0.receiver_ready = 1'b1;
    collect(40);
    chk("drain_n0", g0.size(), 16);
    chk("drain_n1", g1.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < g0.size()) chk("drain_d0", g0[i], i + 1);
      if (i < g1.size()) chk("drain_d1", g1[i], i + 1);
    end
    chk("drain_empty", b0.empty, 1);
    b0.receiver_ready = 1'b0;
    b0.clear_overflow = 1'b1;
    cyc();
    b0.clear_overflow = 1'b0;
    chk("ovf_clr", b0.overflow, 0);

    // output pacing in both modes
    for (int i = 0; i < 8; i++) wr(21'(32'h100 + i));
    chk("rate_lvl", b0.level, 8);
    b0.receiver_ready = 1'b1;
    p0 = '0;
    p1 = '0;
    g0.delete();
    g1.delete();
    for (int k = 0; k < 16; k++) begin
      cyc();
      p0[k] = b0.out_data_available;
      p1[k] = b1.out_data_available;
      if (p0[k]) g0.push_back(b0.out_data);
      if (p1[k]) g1.push_back(b1.out_data);
    end
    chk("rate_pat0", p0, 16'h5555);
    chk("rate_pat1", p1, 16'h00ff);
    for (int i = 0; i < 8; i++) begin
      if (i < g0.size()) chk("rate_d0", g0[i], 32'h100 + i);
      if (i < g1.size()) chk("rate_d1", g1[i], 32'h100 + i);
    end
    b0.receiver_ready = 1'b0;

    // simultaneous write and pop
    for (int i = 0; i < 5; i++) wr(21'(32'h200 + i));
    chk("sim_pre", b0.level, 5);
    b0.in_data = 21'h205;
    b0.in_data_available = 1'b1;
    b0.receiver_ready = 1'b1;
    cyc();
    b0.in_data_available = 1'b0;
    b0.receiver_ready = 1'b0;
    chk("sim_lvl0", b0.level, 5);
    chk("sim_lvl1", b1.level, 5);
    chk("sim_out0", b0.out_data, 32'h200);
    chk("sim_oda1", b1.out_data_available, 1);
    for (int j = 0; j < 11; j++) wr(21'(32'h210 + j));
    chk("sim_full", b0.full, 1);
    b0.in_data = 21'h2ff;
    b0.in_data_available = 1'b1;
    b0.receiver_ready = 1'b1;
    cyc();
    b0.in_data_available = 1'b0;
    chk("simf_lvl0", b0.level, 15);
    chk("simf_lvl1", b1.level, 15);
    chk("simf_ovf", b0.overflow, 1);
    chk("simf_out", b0.out_data, 32'h201);
    collect(40);
    chk("simd_n0", g0.size(), 15);
    chk("simd_n1", g1.size(), 15);
    chk("simd_last", b0.out_data, 32'h21a);
    b0.receiver_ready = 1'b0;
    b0.clear_overflow = 1'b1;
    cyc();
    b0.clear_overflow = 1'b0;

    // flush beats same-cycle write and pop
    for (int i = 0; i < 9; i++) wr(21'(32'h300 + i));
    chk("fl_pre", b0.level, 9);
    b0.flush = 1'b1;
    b0.in_data = 21'h3ff;
    b0.in_data_available = 1'b1;
    b0.receiver_ready = 1'b1;
    cyc();
    b0.flush = 1'b0;
    b0.in_data_available = 1'b0;
    b0.receiver_ready = 1'b0;
    chk("fl_lvl", b0.level, 0);
    chk("fl_oda", b0.out_data_available, 0);
    chk("fl_out", b0.out_data, 32'h21a);
    chk("fl_ovf", b0.overflow, 0);
    cyc();
    chk("fl_lvl2", b0.level, 0);

    // drop together with clear: set wins
    for (int i = 0; i < 16; i++) wr(21'(32'h400 + i));
    b0.in_data_available = 1'b1;
    b0.clear_overflow = 1'b1;
    cyc();
    b0.in_data_available = 1'b0;
    chk("pri_set", b0.overflow, 1);
    cyc();
    b0.clear_overflow = 1'b0;
    chk("pri_clr", b0.overflow, 0);
    b0.flush = 1'b1;
    cyc();
    b0.flush = 1'b0;
    chk("pri_flush", b0.empty, 1);

    // random soak across pointer wraps
    cnt[0] = 0;
    cnt[1] = 0;
    om[0] = 1'b0;
    om[1] = 1'b0;
    n = 0;
    for (int g = 0; g < 6000 && n < 1000; g++) begin
      b0.in_data_available = 1'($urandom_range(0, 1));
      b0.in_data = 21'($urandom);
      b0.receiver_ready = 1'($urandom_range(0, 1));
      if (b0.in_data_available) n++;
      soak_step();
    end
    chk("soak_bound", n, 1000);
    b0.in_data_available = 1'b0;
    b0.receiver_ready = 1'b1;
    for (int k = 0; k < 60; k++) soak_step();
    chk("soak_q0", q0.size(), 0);
    chk("soak_q1", q1.size(), 0);
    chk("soak_end", b0.empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
